// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped branch history/target table with EX-stage resolve and halt FSM
// Optional br_count/mp_count statistics outputs are enabled by defining BRANCH_STATS_EN.
module branch_predict_unit #(
    parameter int PC_W      = 9,
    parameter int BHT_DEPTH = 16,
    parameter int CTR_W     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic             ex_branch,
    input  logic             ex_halt,
    input  logic [31:0]      ex_alu_result,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pred_target,
    output logic [31:0]      PC_Imm,
    output logic [31:0]      PC_Four,
    output logic [31:0]      BrPC,
    output logic             PcSel,
    output logic             flush,
    output logic             halted
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      br_count,
    output logic [31:0]      mp_count
`endif
);

    localparam int IW    = $clog2(BHT_DEPTH);
    localparam int TAG_W = PC_W - IW - 2;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

    typedef enum logic {RUN, HALTED} state_t;

    state_t           state_q;
    logic [PC_W-1:0]  halt_pc_q;
    logic             valid_q  [BHT_DEPTH];
    logic [TAG_W-1:0] tag_q    [BHT_DEPTH];
    logic [PC_W-1:0]  target_q [BHT_DEPTH];
    logic [CTR_W-1:0] ctr_q    [BHT_DEPTH];
    logic [CTR_W-1:0] ctr_d;

    logic [IW-1:0]    if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             run, act_taken, halt_now, mispredict, br_upd, inval;
    logic             unused_bits;

    assign if_idx = if_pc[IW+1:2];
    assign if_tag = if_pc[PC_W-1:IW+2];
    assign ex_idx = ex_pc[IW+1:2];
    assign ex_tag = ex_pc[PC_W-1:IW+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign pred_taken  = if_hit & ctr_q[if_idx][CTR_W-1];
    assign pred_target = if_hit ? target_q[if_idx] : '0;

    assign PC_Imm  = 32'(ex_pc) + ex_imm;
    assign PC_Four = 32'(ex_pc) + 32'd4;

    assign run        = (state_q == RUN);
    assign act_taken  = ex_valid & ex_branch & ex_alu_result[0];
    assign halt_now   = ex_valid & ex_halt;
    assign mispredict = ex_valid & run & ~ex_halt &
                        ((ex_branch & (act_taken != ex_pred_taken)) |
                         (act_taken & ex_pred_taken & (ex_pred_target != PC_Imm[PC_W-1:0])) |
                         (~ex_branch & ex_pred_taken));
    assign br_upd     = ex_valid & ex_branch & ~ex_halt & run;
    assign inval      = ex_valid & ~ex_branch & ex_pred_taken & ~ex_halt & run & ex_hit;

    assign flush  = mispredict;
    assign halted = ~run;
    assign PcSel  = mispredict | halt_now | halted;

    always_comb begin
        BrPC = '0;
        if (halted)          BrPC = 32'(halt_pc_q);
        else if (halt_now)   BrPC = 32'(ex_pc);
        else if (act_taken)  BrPC = PC_Imm;
        else if (mispredict) BrPC = PC_Four;
    end

    always_comb begin
        ctr_d = ctr_q[ex_idx];
        if (act_taken) begin
            if (ctr_d != CTR_MAX) ctr_d = ctr_d + CTR_ONE;
        end else if (ctr_d != '0) begin
            ctr_d = ctr_d - CTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            halt_pc_q <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            if (run && halt_now) begin
                state_q   <= HALTED;
                halt_pc_q <= ex_pc;
            end
            if (br_upd) begin
                if (ex_hit) begin
                    ctr_q[ex_idx] <= ctr_d;
                end else if (act_taken) begin
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_tag;
                    target_q[ex_idx] <= PC_Imm[PC_W-1:0];
                    ctr_q[ex_idx]    <= CTR_WT;
                end
            end else if (inval) begin
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, mp_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            if (br_upd)     br_count_q <= br_count_q + 32'd1;
            if (mispredict) mp_count_q <= mp_count_q + 32'd1;
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;
`endif

    assign unused_bits = ^{ex_alu_result[31:1], if_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit (default parameters)
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [8:0]  pred_target;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] ex_imm;
    logic        ex_branch;
    logic        ex_halt;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [8:0]  ex_pred_target;
    logic [31:0] PC_Imm, PC_Four, BrPC;
    logic        PcSel, flush, halted;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count, mp_count;
`endif

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_halt(ex_halt), .ex_alu_result(ex_alu_result),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .PC_Imm(PC_Imm), .PC_Four(PC_Four), .BrPC(BrPC),
        .PcSel(PcSel), .flush(flush), .halted(halted)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count), .mp_count(mp_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [8:0]  if_pc;
        logic        ev;
        logic [8:0]  epc;
        logic [31:0] imm;
        logic        br, hlt, alu, ept;
        logic [8:0]  eptgt;
        logic        x_pt;
        logic [8:0]  x_ptgt;
        logic        x_pcsel, x_flush, x_halted;
        logic [31:0] x_brpc;
    } row_t;

    typedef logic [44:0] obs_t;

    obs_t        sb[$];
    logic [31:0] sb_arith[$];
    row_t        cur;
    int          passed = 0;
    int          total  = 0;
    int          exp_br = 0;
    int          exp_mp = 0;

    function automatic row_t mk(input logic rst_n, input logic [8:0] ipc, input logic ev,
                                input logic [8:0] epc, input logic [31:0] imm,
                                input logic br, input logic hlt, input logic alu,
                                input logic ept, input logic [8:0] eptgt,
                                input logic x_pt, input logic [8:0] x_ptgt,
                                input logic x_pcsel, input logic x_flush,
                                input logic x_halted, input logic [31:0] x_brpc);
        row_t r;
        r.rst_n = rst_n; r.if_pc = ipc; r.ev = ev; r.epc = epc; r.imm = imm;
        r.br = br; r.hlt = hlt; r.alu = alu; r.ept = ept; r.eptgt = eptgt;
        r.x_pt = x_pt; r.x_ptgt = x_ptgt; r.x_pcsel = x_pcsel; r.x_flush = x_flush;
        r.x_halted = x_halted; r.x_brpc = x_brpc;
        return r;
    endfunction

    task automatic apply(input row_t r);
        logic [31:0] rnd;
        rnd            = $urandom();
        reset          = r.rst_n;
        if_pc          = r.if_pc;
        ex_valid       = r.ev;
        ex_pc          = r.epc;
        ex_imm         = r.imm;
        ex_branch      = r.br;
        ex_halt        = r.hlt;
        ex_alu_result  = {rnd[31:1], r.alu};
        ex_pred_taken  = r.ept;
        ex_pred_target = r.eptgt;
        sb.push_back({r.x_pt, r.x_ptgt, r.x_pcsel, r.x_flush, r.x_halted, r.x_brpc});
        cur = r;
    endtask

    task automatic advance();
        if (!cur.rst_n) begin
            exp_br = 0;
            exp_mp = 0;
        end else begin
            if (cur.ev && cur.br && !cur.hlt && !cur.x_halted) exp_br++;
            if (cur.x_flush) exp_mp++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        obs_t e;
        rows.push_back(mk(0, 9'h010, 0, 9'h000, 32'h0,  0,0,0,0, 9'h0, 0, 9'h0, 0,0,0, 32'h0));
        rows.push_back(mk(0, 9'h010, 1, 9'h044, 32'h0,  0,1,0,0, 9'h0, 0, 9'h0, 1,0,0, 32'h44));
        rows.push_back(mk(0, 9'h020, 1, 9'h020, 32'h40, 1,0,1,0, 9'h0, 0, 9'h0, 1,1,0, 32'h60));
        rows.push_back(mk(0, 9'h020, 0, 9'h000, 32'h0,  0,0,0,0, 9'h0, 0, 9'h0, 0,0,0, 32'h0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({pred_taken, pred_target, PcSel, flush, halted, BrPC} !== e)
                $display("FAIL reset[%0d] got pt=%b tgt=%h pcsel=%b flush=%b halted=%b brpc=%h want %h",
                         i, pred_taken, pred_target, PcSel, flush, halted, BrPC, e);
            else passed++;
            advance();
        end
    endtask

    task automatic test_halt();
        row_t rows[$];
        obs_t e;
        rows.push_back(mk(1, 9'h044, 1, 9'h044, 32'h40, 1,1,1,0, 9'h0, 0, 9'h0, 1,0,0, 32'h44));
        rows.push_back(mk(1, 9'h044, 0, 9'h000, 32'h0,  0,0,0,0, 9'h0, 0, 9'h0, 1,0,1, 32'h44));
        rows.push_back(mk(1, 9'h044, 1, 9'h020, 32'h40, 1,0,1,0, 9'h0, 0, 9'h0, 1,0,1, 32'h44));
        rows.push_back(mk(1, 9'h020, 1, 9'h080, 32'h0,  0,1,0,0, 9'h0, 0, 9'h0, 1,0,1, 32'h44));
        rows.push_back(mk(0, 9'h044, 0, 9'h000, 32'h0,  0,0,0,0, 9'h0, 0, 9'h0, 0,0,0, 32'h0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({pred_taken, pred_target, PcSel, flush, halted, BrPC} !== e)
                $display("FAIL halt[%0d] got pt=%b tgt=%h pcsel=%b flush=%b halted=%b brpc=%h want %h",
                         i, pred_taken, pred_target, PcSel, flush, halted, BrPC, e);
            else passed++;
            advance();
        end
    endtask

    task automatic test_alloc();
        row_t rows[$];
        obs_t e;
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,1,0, 9'h0, 0, 9'h000, 1,1,0, 32'h60));
        rows.push_back(mk(1, 9'h020, 0, 9'h000, 32'h0,  0,0,0,0, 9'h0, 1, 9'h060, 0,0,0, 32'h0));
        rows.push_back(mk(1, 9'h120, 0, 9'h000, 32'h0,  0,0,0,0, 9'h0, 0, 9'h000, 0,0,0, 32'h0));
        rows.push_back(mk(1, 9'h010, 1, 9'h010, 32'h8,  1,0,0,0, 9'h0, 0, 9'h000, 0,0,0, 32'h0));
        rows.push_back(mk(1, 9'h010, 0, 9'h000, 32'h0,  0,0,0,0, 9'h0, 0, 9'h000, 0,0,0, 32'h0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({pred_taken, pred_target, PcSel, flush, halted, BrPC} !== e)
                $display("FAIL alloc[%0d] got pt=%b tgt=%h pcsel=%b flush=%b halted=%b brpc=%h want %h",
                         i, pred_taken, pred_target, PcSel, flush, halted, BrPC, e);
            else passed++;
            advance();
        end
    endtask

    task automatic test_counter();
        row_t rows[$];
        obs_t e;
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,1,1, 9'h064, 1, 9'h060, 1,1,0, 32'h60));
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,1,1, 9'h060, 1, 9'h060, 0,0,0, 32'h60));
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,0,1, 9'h060, 1, 9'h060, 1,1,0, 32'h24));
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,0,1, 9'h060, 1, 9'h060, 1,1,0, 32'h24));
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,0,0, 9'h000, 0, 9'h060, 0,0,0, 32'h0));
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,0,0, 9'h000, 0, 9'h060, 0,0,0, 32'h0));
        rows.push_back(mk(1, 9'h020, 0, 9'h000, 32'h0,  0,0,0,0, 9'h000, 0, 9'h060, 0,0,0, 32'h0));
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,1,0, 9'h000, 0, 9'h060, 1,1,0, 32'h60));
        rows.push_back(mk(1, 9'h020, 0, 9'h000, 32'h0,  0,0,0,0, 9'h000, 0, 9'h060, 0,0,0, 32'h0));
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h40, 1,0,1,0, 9'h000, 0, 9'h060, 1,1,0, 32'h60));
        rows.push_back(mk(1, 9'h020, 0, 9'h000, 32'h0,  0,0,0,0, 9'h000, 1, 9'h060, 0,0,0, 32'h0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({pred_taken, pred_target, PcSel, flush, halted, BrPC} !== e)
                $display("FAIL counter[%0d] got pt=%b tgt=%h pcsel=%b flush=%b halted=%b brpc=%h want %h",
                         i, pred_taken, pred_target, PcSel, flush, halted, BrPC, e);
            else passed++;
            advance();
        end
    endtask

    task automatic test_nonbranch();
        row_t rows[$];
        obs_t e;
        rows.push_back(mk(1, 9'h020, 1, 9'h020, 32'h0,  0,0,0,1, 9'h060, 1, 9'h060, 1,1,0, 32'h24));
        rows.push_back(mk(1, 9'h020, 0, 9'h000, 32'h0,  0,0,0,0, 9'h000, 0, 9'h000, 0,0,0, 32'h0));
        rows.push_back(mk(1, 9'h030, 1, 9'h030, 32'h40, 0,0,1,0, 9'h000, 0, 9'h000, 0,0,0, 32'h0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({pred_taken, pred_target, PcSel, flush, halted, BrPC} !== e)
                $display("FAIL nonbranch[%0d] got pt=%b tgt=%h pcsel=%b flush=%b halted=%b brpc=%h want %h",
                         i, pred_taken, pred_target, PcSel, flush, halted, BrPC, e);
            else passed++;
            advance();
        end
    endtask

    task automatic test_wrap();
        logic [8:0]  pcs  [3] = '{9'h1FC, 9'h001, 9'h1FF};
        logic [31:0] imms [3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] ximm [3] = '{32'h0000_01EC, 32'h0000_0000, 32'h8000_01FE};
        logic [31:0] xfour[3] = '{32'h0000_0200, 32'h0000_0005, 32'h0000_0203};
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
            apply(mk(1, 9'h000, 0, pcs[i], imms[i], 0,0,0,0, 9'h0, 0, 9'h0, 0,0,0, 32'h0));
            sb_arith.push_back(ximm[i]);
            sb_arith.push_back(xfour[i]);
            @(negedge clk);
            void'(sb.pop_front());
            e = sb_arith.pop_front();
            total++;
            if (PC_Imm !== e) $display("FAIL pc_imm[%0d] got %h want %h", i, PC_Imm, e);
            else passed++;
            e = sb_arith.pop_front();
            total++;
            if (PC_Four !== e) $display("FAIL pc_four[%0d] got %h want %h", i, PC_Four, e);
            else passed++;
            advance();
        end
    endtask

    task automatic test_stats();
`ifdef BRANCH_STATS_EN
        @(negedge clk);
        total++;
        if (br_count !== 32'(exp_br)) $display("FAIL br_count got %0d want %0d", br_count, exp_br);
        else passed++;
        total++;
        if (mp_count !== 32'(exp_mp)) $display("FAIL mp_count got %0d want %0d", mp_count, exp_mp);
        else passed++;
`endif
    endtask

    initial begin
        reset = 1'b0; if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_imm = '0;
        ex_branch = 1'b0; ex_halt = 1'b0; ex_alu_result = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
        test_reset();
        test_halt();
        test_alloc();
        test_counter();
        test_nonbranch();
        test_wrap();
        test_stats();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 9, which is the PC width in bits.
REQ-002 The block SHALL have parameter BHT_DEPTH, default 16, which is the table entry count; it SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter CTR_W, default 2, which is the saturating counter width; it SHALL be at least 2.
REQ-004 The block SHALL have one clock and one asynchronous, active-low reset.
REQ-005 Port clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 Port reset  in  1  asynchronous active-low reset.
REQ-007 Port if_pc  in  PC_W  fetch-stage PC.
REQ-008 Port pred_taken  out  1  fetch prediction.
REQ-009 Port pred_target  out  PC_W  predicted target.
REQ-010 Port ex_valid  in  1  EX stage holds a valid instruction.
REQ-011 Port ex_pc  in  PC_W  PC of the EX instruction.
REQ-012 Port ex_imm  in  32  branch immediate.
REQ-013 Port ex_branch  in  1  EX instruction is a conditional branch.
REQ-014 Port ex_halt  in  1  EX instruction is a halt.
REQ-015 Port ex_alu_result  in  32  ALU result; bit 0 set means the condition is true.
REQ-016 Port ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction.
REQ-017 Port ex_pred_target  in  PC_W  predicted target carried down the pipe with the EX instruction.
REQ-018 Port PC_Imm  out  32  {zero-extended ex_pc} + ex_imm, modulo 2^32.
REQ-019 Port PC_Four  out  32  {zero-extended ex_pc} + 4, modulo 2^32.
REQ-020 Port BrPC  out  32  redirect target.
REQ-021 Port PcSel  out  1  when 1, fetch SHALL take BrPC.
REQ-022 Port flush  out  1  mispredict; squash IF and ID.
REQ-023 Port halted  out  1  the unit is in the HALTED state.

Function
REQ-024 Index SHALL be pc[IW+1:2] with IW=log2(BHT_DEPTH); tag SHALL be pc[PC_W-1:IW+2]; each entry SHALL hold valid, tag, target[PC_W-1:0] and ctr[CTR_W-1:0].
REQ-025 Lookup SHALL be combinational from if_pc: hit = valid and tag match; pred_taken = hit and ctr MSB; pred_target = the entry target when hit, else 0.
REQ-026 The block SHALL define act_taken = ex_valid & ex_branch & ex_alu_result[0].
REQ-027 mispredict SHALL be asserted when ex_valid, state RUN, ex_halt=0, and any of: (a) ex_branch and act_taken != ex_pred_taken; (b) act_taken and ex_pred_taken and ex_pred_target != PC_Imm[PC_W-1:0]; (c) !ex_branch and ex_pred_taken.
REQ-028 flush SHALL equal mispredict; mispredict and flush SHALL be 0 whenever halted=1.
REQ-029 PcSel SHALL equal mispredict | (ex_valid & ex_halt) | halted.
REQ-030 BrPC priority SHALL be: halted gives {0, halt_pc}; else ex_valid & ex_halt gives {0, ex_pc}; else act_taken gives PC_Imm; else mispredict gives PC_Four; else 0.
REQ-031 FSM states SHALL be RUN and HALTED; RUN SHALL go to HALTED on ex_valid & ex_halt, latching halt_pc=ex_pc; HALTED SHALL be left only by reset.
REQ-032 Halt SHALL take priority over every branch action in the same cycle, and no table update SHALL occur on a halt cycle.
REQ-033 Update SHALL occur at the edge after ex_valid & ex_branch in RUN; on a hit, ctr SHALL do a saturating +1 if act_taken and a saturating -1 otherwise, with no wrap.
REQ-034 Update on a miss with act_taken SHALL allocate the entry (overwriting it): valid=1, tag, target=PC_Imm[PC_W-1:0], ctr=2^(CTR_W-1) (weakly taken).
REQ-035 A miss with act_taken=0 SHALL make no allocation.
REQ-036 Case (c) SHALL clear valid for the ex_pc entry if it hits.
REQ-037 A lookup and an update to the same index in the same cycle SHALL return pre-update contents (no bypass).
REQ-038 Only the entry at the update index SHALL change per cycle.

Reset
REQ-039 While reset=0, every valid SHALL be 0, every ctr SHALL be 2^(CTR_W-1)-1 (weakly not-taken), every tag and target SHALL be 0, state SHALL be RUN and halt_pc SHALL be 0.
REQ-040 During reset, outputs SHALL be driven from the reset state and the current inputs; halted SHALL be 0.
REQ-041 Reset asserted mid-halt SHALL return the unit to RUN immediately (asynchronously).

Configuration
REQ-042 With BRANCH_STATS_EN defined, outputs br_count[31:0] and mp_count[31:0] SHALL exist, reset to 0, increment on each branch update and on each mispredict cycle respectively, and wrap at 2^32.
REQ-043 With BRANCH_STATS_EN undefined, those ports and their counters SHALL be absent.

Verification
REQ-044 After reset, if_pc=0x010 SHALL give pred_taken=0 and pred_target=0; ex_valid=0 SHALL give PcSel=0, flush=0.
REQ-045 ex_pc=0x020, imm=0x40, branch, alu[0]=1, pred 0 SHALL give flush=1, PcSel=1, BrPC=0x60; next cycle, if_pc=0x020 SHALL give pred_taken=1, pred_target=0x060.
REQ-046 Repeating the same branch three times taken then twice not-taken (CTR_W=2) SHALL move ctr 10 to 11 to 11 (saturated), then 10, then 01, with pred_taken=0 afterward.
REQ-047 ex_halt with ex_pc=0x044 together with a mispredicting branch signal SHALL give BrPC=0x44, PcSel=1, flush=0, halted=1 from the next cycle onward, and no table change; pulsing reset low SHALL give halted=0.
REQ-048 A non-branch with ex_pred_taken=1 at ex_pc=0x020 SHALL give flush=1 and BrPC=0x24, and the entry SHALL be invalidated.
REQ-049 ex_pc=0x1FC, imm=0xFFFFFFF0 SHALL give PC_Imm=0x1EC and PC_Four=0x200; with BRANCH_STATS_EN, br_count and mp_count SHALL match the bench's count of branch updates and mispredict cycles.
